// File: rtl/fmdsp_pkg.sv
// Shared types and helpers for the FMDSP pipelined MAC.
// Combinational definitions only. No latency.
// No backpressure. Defining FMDSP_SAT_EN makes overflowing lanes saturate.
package fmdsp_pkg;

    typedef enum logic [1:0] {
        MODE_DUAL = 2'd0,
        MODE_HALF = 2'd1,
        MODE_FULL = 2'd2
    } mode_e;

`ifdef FMDSP_SAT_EN
    localparam bit SAT_ENABLED = 1'b1;
`else
    localparam bit SAT_ENABLED = 1'b0;
`endif

    function automatic int lane_count(input logic [1:0] mode);
        return (mode == MODE_DUAL) ? 2 : 1;
    endfunction

    function automatic int lane_width(input logic [1:0] mode, input int width);
        return (mode == MODE_DUAL) ? width : 2 * width;
    endfunction

    // Guard bits cover the largest left shift plus two addends.
    function automatic int ext_width(input int lw, input int sb);
        return lw + (1 << sb) + 1;
    endfunction

endpackage

// File: rtl/fmdsp_lane_shift_add.sv
// One lane of shift, add addend and accumulator, with signed overflow detection.
// Combinational. No latency.
// No backpressure. Saturates on overflow when FMDSP_SAT_EN is defined, otherwise wraps.
module fmdsp_lane_shift_add
    import fmdsp_pkg::*;
#(
    parameter int LW = 32,
    parameter int SB = 2
) (
    input  logic [LW-1:0] prod,
    input  logic [SB-1:0] shift_amount,
    input  logic          shift_dir,
    input  logic [LW-1:0] addend,
    input  logic [LW-1:0] acc,
    output logic [LW-1:0] res,
    output logic          ovf
);
    localparam int EW = ext_width(LW, SB);
    localparam logic [LW-1:0] SAT_MAX = {1'b0, {(LW-1){1'b1}}};
    localparam logic [LW-1:0] SAT_MIN = {1'b1, {(LW-1){1'b0}}};

    logic signed [EW-1:0] prod_x;
    logic signed [EW-1:0] addend_x;
    logic signed [EW-1:0] acc_x;
    logic signed [EW-1:0] shifted;
    logic signed [EW-1:0] sum;

    always_comb begin
        prod_x   = {{(EW-LW){prod[LW-1]}}, prod};
        addend_x = {{(EW-LW){addend[LW-1]}}, addend};
        acc_x    = {{(EW-LW){acc[LW-1]}}, acc};
        shifted  = shift_dir ? (prod_x >>> shift_amount) : (prod_x << shift_amount);
        sum      = shifted + addend_x + acc_x;
        // Fits the lane only if every bit above the lane sign bit copies it.
        ovf      = !((&sum[EW-1:LW-1]) || !(|sum[EW-1:LW-1]));
        res      = sum[LW-1:0];
        if (SAT_ENABLED && ovf) begin
            res = sum[EW-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/fmdsp_pipe_mac.sv
// Pipelined fracturable signed multiply-shift-add/accumulate with NUM_ACC banks.
// Latency PIPE+1 cycles from accept to out_valid, one op per cycle.
// Stall when out_valid && !out_ready freezes every stage. FMDSP_SAT_EN selects saturation.
module fmdsp_pipe_mac
    import fmdsp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_ACC    = 4,
    parameter int SHIFT_BITS = 2,
    parameter int PIPE       = 2,
    localparam int AW        = $clog2(NUM_ACC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            mode,
    input  logic                  mac,
    input  logic                  acc_clr,
    input  logic [AW-1:0]         acc_sel,
    input  logic [SHIFT_BITS-1:0] shift_amount,
    input  logic                  shift_dir,
    input  logic [WIDTH-1:0]      aa,
    input  logic [WIDTH-1:0]      bb,
    input  logic [2*WIDTH-1:0]    cc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*WIDTH-1:0]    out,
    output logic                  ovf
);
    localparam int H  = WIDTH / 2;
    localparam int W2 = 2 * WIDTH;
    localparam int L  = PIPE - 1;

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    logic signed [WIDTH-1:0] a_lo, b_lo, a_hi, b_hi, p_lo, p_hi;
    logic signed [W2-1:0]    a_half_x, a_x, b_x, p_half, p_full;
    logic        [W2-1:0]    prod_in;

    always_comb begin
        a_lo     = {{H{aa[H-1]}}, aa[H-1:0]};
        b_lo     = {{H{bb[H-1]}}, bb[H-1:0]};
        a_hi     = {{H{aa[WIDTH-1]}}, aa[WIDTH-1:H]};
        b_hi     = {{H{bb[WIDTH-1]}}, bb[WIDTH-1:H]};
        p_lo     = a_lo * b_lo;
        p_hi     = a_hi * b_hi;
        a_half_x = {{(W2-H){aa[H-1]}}, aa[H-1:0]};
        a_x      = {{WIDTH{aa[WIDTH-1]}}, aa};
        b_x      = {{WIDTH{bb[WIDTH-1]}}, bb};
        p_half   = a_half_x * b_x;
        p_full   = a_x * b_x;
        if (mode == MODE_DUAL) begin
            prod_in = {p_hi, p_lo};
        end else if (mode == MODE_HALF) begin
            prod_in = p_half;
        end else begin
            prod_in = p_full;
        end
    end

    logic                  s_vld  [PIPE];
    logic [W2-1:0]         s_prod [PIPE];
    logic [1:0]            s_mode [PIPE];
    logic                  s_mac  [PIPE];
    logic                  s_clr  [PIPE];
    logic [AW-1:0]         s_sel  [PIPE];
    logic [SHIFT_BITS-1:0] s_sh   [PIPE];
    logic                  s_dir  [PIPE];
    logic [W2-1:0]         s_cc   [PIPE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE; i++) s_vld[i] <= 1'b0;
        end else if (!stall) begin
            s_vld[0] <= in_valid;
            for (int i = 1; i < PIPE; i++) s_vld[i] <= s_vld[i-1];
        end
    end

    // Payload is qualified by s_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s_prod[0] <= prod_in;
            s_mode[0] <= mode;
            s_mac[0]  <= mac;
            s_clr[0]  <= acc_clr;
            s_sel[0]  <= acc_sel;
            s_sh[0]   <= shift_amount;
            s_dir[0]  <= shift_dir;
            s_cc[0]   <= cc;
            for (int i = 1; i < PIPE; i++) begin
                s_prod[i] <= s_prod[i-1];
                s_mode[i] <= s_mode[i-1];
                s_mac[i]  <= s_mac[i-1];
                s_clr[i]  <= s_clr[i-1];
                s_sel[i]  <= s_sel[i-1];
                s_sh[i]   <= s_sh[i-1];
                s_dir[i]  <= s_dir[i-1];
                s_cc[i]   <= s_cc[i-1];
            end
        end
    end

    logic [W2-1:0] bank [NUM_ACC];
    logic [W2-1:0] acc_rd, res_full, res;
    logic [WIDTH-1:0] res_lo, res_hi;
    logic ovf_lo, ovf_hi, ovf_full, res_ovf;

    assign acc_rd = (s_mac[L] && !s_clr[L]) ? bank[s_sel[L]] : '0;

    fmdsp_lane_shift_add #(.LW(lane_width(MODE_DUAL, WIDTH)), .SB(SHIFT_BITS)) u_lane_lo (
        .prod(s_prod[L][WIDTH-1:0]), .shift_amount(s_sh[L]), .shift_dir(s_dir[L]),
        .addend(s_cc[L][WIDTH-1:0]), .acc(acc_rd[WIDTH-1:0]), .res(res_lo), .ovf(ovf_lo)
    );

    fmdsp_lane_shift_add #(.LW(lane_width(MODE_DUAL, WIDTH)), .SB(SHIFT_BITS)) u_lane_hi (
        .prod(s_prod[L][W2-1:WIDTH]), .shift_amount(s_sh[L]), .shift_dir(s_dir[L]),
        .addend(s_cc[L][W2-1:WIDTH]), .acc(acc_rd[W2-1:WIDTH]), .res(res_hi), .ovf(ovf_hi)
    );

    fmdsp_lane_shift_add #(.LW(lane_width(MODE_FULL, WIDTH)), .SB(SHIFT_BITS)) u_lane_full (
        .prod(s_prod[L]), .shift_amount(s_sh[L]), .shift_dir(s_dir[L]),
        .addend(s_cc[L]), .acc(acc_rd), .res(res_full), .ovf(ovf_full)
    );

    always_comb begin
        if (lane_count(s_mode[L]) == 2) begin
            res     = {res_hi, res_lo};
            res_ovf = ovf_hi || ovf_lo;
        end else begin
            res     = res_full;
            res_ovf = ovf_full;
        end
    end

    // Bank write shares the retire condition with the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            ovf       <= 1'b0;
            for (int k = 0; k < NUM_ACC; k++) bank[k] <= '0;
        end else if (!stall) begin
            out_valid <= s_vld[L];
            if (s_vld[L]) begin
                out            <= res;
                ovf            <= res_ovf;
                bank[s_sel[L]] <= res;
            end
        end
    end

endmodule

// File: tb/tb_fmdsp_pipe_mac.sv
// Scoreboard bench for fmdsp_pipe_mac: directed ops push expected results, a monitor pops on handshake.
module tb_fmdsp_pipe_mac;
    localparam int WIDTH = 32, NUM_ACC = 4, SHIFT_BITS = 2, PIPE = 2;

`ifdef FMDSP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, mac, acc_clr, shift_dir, out_valid, out_ready, ovf;
    logic [1:0]  mode, acc_sel, shift_amount;
    logic [31:0] aa, bb;
    logic [63:0] cc, out;

    typedef struct packed {
        logic [63:0] o;
        logic        v;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int k;

    always #5 clk = ~clk;

    fmdsp_pipe_mac #(.WIDTH(WIDTH), .NUM_ACC(NUM_ACC), .SHIFT_BITS(SHIFT_BITS), .PIPE(PIPE)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .mac(mac), .acc_clr(acc_clr), .acc_sel(acc_sel), .shift_amount(shift_amount),
        .shift_dir(shift_dir), .aa(aa), .bb(bb), .cc(cc), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .ovf(ovf)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Called at a rising edge; returns at the edge where the op was accepted.
    task automatic send(input logic [1:0] m, input logic mc, input logic clr, input logic [1:0] sel,
                        input logic [1:0] sa, input logic sd, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] c, input logic [63:0] eo, input logic ev);
        int w;
        #1;
        mode = m; mac = mc; acc_clr = clr; acc_sel = sel; shift_amount = sa; shift_dir = sd;
        aa = a; bb = b; cc = c; in_valid = 1'b1;
        w = 0;
        while (in_ready !== 1'b1 && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back('{o: eo, v: ev});
        end
    endtask

    task automatic idle(input int n);
        #1 in_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got=%h ovf=%b", out, ovf);
            end else begin
                mon_e = exp_q.pop_front();
                if (out !== mon_e.o || ovf !== mon_e.v) begin
                    errors++;
                    $display("FAIL sb_result got=%h ovf=%b want=%h ovf=%b", out, ovf, mon_e.o, mon_e.v);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'd0; mac = 1'b0; acc_clr = 1'b0;
        acc_sel = 2'd0; shift_amount = 2'd0; shift_dir = 1'b0; aa = '0; bb = '0; cc = '0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", out, 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);

        // Basic full-width op and accept-to-valid latency.
        send(2'd2, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 32'd3, -32'sd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        #1 in_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk); k++;
        end while (out_valid !== 1'b1 && k < 20);
        chk("latency", 64'(k), 64'(PIPE + 1));
        @(posedge clk);

        // Back-to-back accumulation into one bank.
        for (int i = 1; i <= 4; i++)
            send(2'd2, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 32'd1, 32'd10, 64'd0, 64'(10 * i), 1'b0);
        idle(1);

        send(2'd0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0, {16'd2, 16'hFFFD}, {16'd4, 16'd5}, 64'd0,
             {32'd8, 32'hFFFF_FFF1}, 1'b0);
        send(2'd0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0, {16'd2, 16'hFFFD}, {16'd4, 16'd5}, {32'd0, 32'd20},
             {32'd8, 32'd5}, 1'b0);
        send(2'd1, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0, 32'h1234_FFFE, 32'h4000_0000, 64'd0,
             64'hFFFF_FFFF_8000_0000, 1'b0);
        send(2'd2, 1'b0, 1'b0, 2'd3, 2'd1, 1'b1, -32'sd7, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        send(2'd0, 1'b0, 1'b0, 2'd3, 2'd2, 1'b0, {16'h7FFF, 16'd0}, {16'h7FFF, 16'd0}, 64'd0,
             SAT ? {32'h7FFF_FFFF, 32'd0} : {32'hFFFC_0004, 32'd0}, 1'b1);
        send(2'd2, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'd0,
             SAT ? 64'h7FFF_FFFF_FFFF_FFFF : 64'd0, 1'b1);
        send(2'd2, 1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 32'd2, 32'd3, 64'd1, 64'd7, 1'b0);
        idle(5);

        // Output stall with three ops in flight.
        send(2'd2, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 32'd100, 32'd1, 64'd0, 64'd100, 1'b0);
        idle(5);
        #1 out_ready = 1'b0;
        for (int i = 1; i <= 3; i++)
            send(2'd2, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 32'd1, 32'd7, 64'd0, 64'(100 + 7 * i), 1'b0);
        #1 in_valid = 1'b0;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_out_first", out, 64'd107);
        repeat (4) @(posedge clk);
        #1;
        chk("stall_out_held", out, 64'd107);
        chk("stall_in_ready_late", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        repeat (8) @(posedge clk);

        // Reset with two ops in flight.
        send(2'd2, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 32'd11, 32'd1, 64'd0, 64'd11, 1'b0);
        send(2'd2, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 32'd22, 32'd1, 64'd0, 64'd22, 1'b0);
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out", out, 64'd0);
        chk("midrst_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        send(2'd2, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 32'd1, 32'd5, 64'd0, 64'd5, 1'b0);
        send(2'd2, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 32'd1, 32'd5, 64'd0, 64'd5, 1'b0);
        idle(1);

        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk); k++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
